// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
// Optional feature macro: PLOADER_CHECKSUM_EN (adds the CSUM trailer state).
package prog_loader_pkg;

  localparam int INSN_LEN   = 32;
  localparam int ADDR_LEN   = 32;
  localparam int DATA_LEN   = 32;

  localparam int HDR_BYTES  = 8;
  localparam int LINE_BYTES = 4 * INSN_LEN / 8;
  localparam int WORD_BYTES = DATA_LEN / 8;

  typedef enum logic [2:0] {
    S_HDR,
    S_IMEM,
    S_DMEM,
    S_CSUM,
    S_DONE
  } state_t;

  // State entered once the last payload phase is finished.
`ifdef PLOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  // Byte index (within the current group) of the byte that completes a group.
  function automatic logic [3:0] last_index(input state_t s);
    case (s)
      S_HDR:   return 4'(HDR_BYTES - 1);
      S_IMEM:  return 4'(LINE_BYTES - 1);
      default: return 4'(WORD_BYTES - 1);
    endcase
  endfunction

endpackage

// File: rtl/ploader_asm.sv
// Byte assembler: inserts incoming bytes into a 128-bit line register.
// Byte i lands in word i/4 (word 0 at [127:96]), little-endian within the word.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   clear            - empty the register after this cycle (group complete)
//   push, byte_in    - insert byte_in at the current index
//   line             - register contents including the byte pushed this cycle
//   word             - line[127:96], the first assembled word
//   count            - number of bytes already held (before this push)
module ploader_asm (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [7:0]   byte_in,
  output logic [127:0] line,
  output logic [31:0]  word,
  output logic [3:0]   count
);

  logic [127:0] line_q;
  logic [3:0]   count_q;
  logic [6:0]   bit_pos;

  // Word k sits at bit (3-k)*32, byte b of that word at +8*b.
  assign bit_pos = {~count_q[3:2], count_q[1:0], 3'b000};

  // Combinational view so the completing byte is visible in the same cycle.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    line = line_q;
    if (push) line[bit_pos +: 8] = byte_in;
  end

  assign word  = line[127:96];
  assign count = count_q;

  // NOTE: reset is sampled on the clock edge (synchronous), not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      line_q  <= '0;
      count_q <= '0;
    end else if (push) begin
      // NOTE: non-blocking assignments for all sequential state avoid ordering races.
      line_q  <= line;
      count_q <= count_q + 4'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: header (ilen, dlen), imem image, data image,
// optional checksum trailer. Produces the program-load write port.
// Optional feature macro: PLOADER_CHECKSUM_EN.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   rx_valid, rx_data  - one-cycle byte strobe from the UART receiver
//   addr, data         - registered write address / data
//   we_128, we_32      - one-cycle imem line / dmem word write strobes
//   done               - sticky load complete
//   err                - sticky checksum mismatch (0 without the checksum feature)
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic [ADDR_LEN-1:0] addr,
  output logic [127:0]        data,
  output logic                we_128,
  output logic                we_32,
  output logic                done,
  output logic                err
);

  localparam int LW = ADDR_LEN - 4;  // whole lines in a byte count
  localparam int WW = ADDR_LEN - 2;  // whole words in a byte count

  state_t              state, next_state;
  logic [LW-1:0]       lines_left;
  logic [WW-1:0]       words_left;
  logic [ADDR_LEN-1:0] wr_ptr;

  logic                accept;
  logic                last_byte;
  logic [127:0]        asm_line;
  logic [31:0]         asm_word;
  logic [3:0]          asm_count;
  logic [LW-1:0]       hdr_lines;
  logic [WW-1:0]       hdr_words;

  assign accept    = rx_valid && (state != S_DONE);
  assign last_byte = accept && (asm_count == last_index(state));

  // Header words land at [127:96] (ilen) and [95:64] (dlen); low bits are floored away.
  assign hdr_lines = asm_line[127:100];
  assign hdr_words = asm_line[95:66];

  ploader_asm u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear   (last_byte),
    .push    (accept),
    .byte_in (rx_data),
    .line    (asm_line),
    .word    (asm_word),
    .count   (asm_count)
  );

  always_comb begin
    next_state = state;
    if (last_byte) begin
      case (state)
        S_HDR: begin
          if (hdr_lines != '0)      next_state = S_IMEM;
          else if (hdr_words != '0) next_state = S_DMEM;
          else                      next_state = S_END;
        end
        S_IMEM: if (lines_left == LW'(1)) next_state = (words_left != '0) ? S_DMEM : S_END;
        S_DMEM: if (words_left == WW'(1)) next_state = S_END;
        S_CSUM: next_state = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      lines_left <= '0;
      words_left <= '0;
      wr_ptr     <= '0;
      addr       <= '0;
      data       <= '0;
      we_128     <= 1'b0;
      we_32      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state  <= next_state;
      we_128 <= 1'b0;
      we_32  <= 1'b0;
      done   <= done | (next_state == S_DONE);
      if (last_byte) begin
        case (state)
          S_HDR: begin
            lines_left <= hdr_lines;
            words_left <= hdr_words;
            wr_ptr     <= '0;
          end
          S_IMEM: begin
            we_128     <= 1'b1;
            addr       <= wr_ptr;
            data       <= asm_line;
            lines_left <= lines_left - LW'(1);
            // dmem addressing restarts at 0 after the last line.
            wr_ptr     <= (lines_left == LW'(1)) ? '0 : wr_ptr + ADDR_LEN'(LINE_BYTES);
          end
          S_DMEM: begin
            we_32      <= 1'b1;
            addr       <= wr_ptr;
            data       <= {asm_word, 96'b0};
            words_left <= words_left - WW'(1);
            wr_ptr     <= wr_ptr + ADDR_LEN'(WORD_BYTES);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PLOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (accept && (state == S_IMEM || state == S_DMEM))
        sum <= sum + {24'b0, rx_data};
      if (last_byte && state == S_CSUM)
        err <= (asm_word != sum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the core/memory top level. It consumes a byte stream from the UART receiver and produces the program-load write port: `prog_loadaddr`, `prog_loaddata`, `prog_imem_we` and `prog_dmem_we`. The stream is a header, then the instruction image, then the data image. While it runs, the top level holds the pipeline in reset through `prog_loading`, and `done` releases it.

## Interface
- `ADDR_LEN`, 32: width of `addr` and of the header length fields.
- `LINE_BYTES`, 16: bytes per imem line. Fixed at 4 × `INSN_LEN`/8.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle. There is no backpressure.
- `rx_data` in 8: received byte.
- `addr` out `ADDR_LEN`: write byte address (imem: line×16; dmem: word×4).
- `data` out 128: write data. imem uses all 128 bits; dmem word is on [127:96], [95:0]=0.
- `we_128` out 1: one-cycle imem line write strobe.
- `we_32` out 1: one-cycle dmem word write strobe.
- `done` out 1: sticky once the load completes.
- `err` out 1: sticky checksum mismatch (see Configuration).

## Operation
- FSM states: HDR → IMEM → DMEM → [CSUM] → DONE.
- Reset drives `state`=HDR, and all counters, `addr`, `data`, `we_128`, `we_32`, `done` and `err` to 0.
- **HDR:** accepts 8 bytes.
  - Bytes 0–3 are `ilen` and bytes 4–7 are `dlen`, both little-endian byte counts.
  - `ilen[3:0]` and `dlen[1:0]` are ignored (floor to whole lines/words).
- **IMEM:** each group of 16 bytes is assembled into one line.
  - Line layout: word k (k=0..3) occupies [127−32k:96−32k]. Bytes within a word are little-endian.
  - Each completed line produces one `we_128` pulse. `addr` starts at 0 and advances by 16 per line.
- **DMEM:** each group of 4 bytes is one little-endian word.
  - Each completed word produces one `we_32` pulse. `addr` restarts at 0 and advances by 4 per word.
- **Phase transitions:**
  - A phase whose floored length is 0 is skipped.
  - From HDR, the FSM goes directly to the first non-empty phase, or to DONE/CSUM.
  - The transition happens on the cycle the last header byte or last payload byte is accepted.
- **DONE:**
  - `done`=1 and stays at 1 until `reset`.
  - Further `rx_valid` bytes are ignored, and no write strobes are produced.
- **Address width:** `addr` increments modulo 2^`ADDR_LEN`. Truncation to the imem/dmem index ranges is done by the consumer.
- **Partial group:** a partial group left at the end of the floored count cannot occur by construction. Bytes beyond the count belong to the next phase.
- **Reset mid-load:** abandons the load immediately. No strobe is produced in the reset cycle or the cycle after.

## Timing
- Byte accepted in cycle N completes a group → `we_*` is high in cycle N+1, with `addr` and `data` stable for that cycle.
- `addr` and `data` are registered and change only in the strobe cycle. They hold their values otherwise.
- `done` rises in cycle N+1 after the final accepted byte, which is the same cycle as the final write strobe.
- Back-to-back `rx_valid` on every cycle is supported. Maximum rate is 1 byte/cycle with no loss.
- `we_128` and `we_32` are never high in the same cycle.

## Configuration
- `PLOADER_CHECKSUM_EN` defined:
  - After DMEM, state CSUM accepts 4 more bytes holding a little-endian 32-bit sum, modulo 2^32, of all payload bytes (header excluded).
  - On the 4th byte, `done`=1 next cycle, and `err`=1 in the same cycle if the sums differ.
- `PLOADER_CHECKSUM_EN` undefined:
  - There is no CSUM state. DMEM (or the last non-empty phase) goes straight to DONE.
  - `err` is tied to 0.

## Structure
- The shared constants package holds:
  - the state encoding;
  - `HDR_BYTES`=8, `LINE_BYTES`=16, `WORD_BYTES`=4;
  - `INSN_LEN`, `ADDR_LEN` and `DATA_LEN`, taken from the existing define/constants headers.
- Sub-module `ploader_asm`: a 128-bit byte shift/insert register with a byte index. It takes `clear` and `push`, and outputs `line`, `word` and `count`. It is instantiated once. The FSM and address counters stay in `prog_loader`.

## Test plan
- **Basic load:** header `ilen`=32, `dlen`=8, then bytes 0x00..0x27 →
  - `we_128` at `addr` 0x0 with data 0x03020100_07060504_0B0A0908_0F0E0D0C;
  - `we_128` at `addr` 0x10;
  - `we_32` at `addr` 0x0 with data[127:96]=0x23222120;
  - `we_32` at `addr` 0x4 with data[127:96]=0x27262524;
  - `done`=1 in the cycle of the last strobe.
- **Empty phases:** `ilen`=0, `dlen`=0 → `done`=1 one cycle after the 8th header byte; no strobes.
- **Floor:** `ilen`=19, `dlen`=6 → exactly 1 `we_128` and 1 `we_32`. The 17th byte goes into DMEM.
- **Gapped input:** `rx_valid` every 3rd cycle vs every cycle → identical strobe sequence, with each strobe exactly 1 cycle after its completing byte.
- **Reset mid-load:** `reset` asserted after the 10th imem byte, then a fresh stream → the first strobe is a `we_128` at `addr` 0 containing only new bytes, and `done`=0 until the new load completes.
- **Checksum (`PLOADER_CHECKSUM_EN`):** 16-byte imem image of 0x01 and a trailer of 0x10 → `err`=0. The same image with a trailer of 0x11 → `err`=1 and `done`=1.
